// File: rtl/autoconfig_pkg.sv
// Shared constants and state encoding for the Zorro II AutoConfig responder.
package autoconfig_pkg;

  localparam logic [7:0] CFG_BASE    = 8'hE8;
  localparam logic [5:0] IDX_BASE_HI = 6'h24;
  localparam logic [5:0] IDX_BASE_LO = 6'h25;
  localparam logic [5:0] IDX_SHUTUP  = 6'h26;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    CONF   = 2'd1,
    SHUTUP = 2'd2
  } ac_state_t;

  // er_Type bits 7:6 board type, bits 2:0 board size
  localparam logic [1:0] ERT_ZORRO2   = 2'b11;
  localparam logic [2:0] ER_SIZE_8M   = 3'b000;
  localparam logic [2:0] ER_SIZE_64K  = 3'b001;
  localparam logic [2:0] ER_SIZE_128K = 3'b010;
  localparam logic [2:0] ER_SIZE_256K = 3'b011;
  localparam logic [2:0] ER_SIZE_512K = 3'b100;
  localparam logic [2:0] ER_SIZE_1M   = 3'b101;
  localparam logic [2:0] ER_SIZE_2M   = 3'b110;
  localparam logic [2:0] ER_SIZE_4M   = 3'b111;

endpackage

// File: rtl/autoconfig_rom.sv
// Config-space nibble lookup; everything but er_Type and $40/$42 reads
// back inverted.
module autoconfig_rom #(
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PROD_ID  = 8'h05,
  parameter logic [31:0] SERIAL   = 32'h00000001,
  parameter logic [7:0]  ER_TYPE  = 8'hD2,
  parameter logic [15:0] DIAG_VEC = 16'h0000
) (
  input  logic [5:0] idx,
  output logic [3:0] nib
);

  always_comb begin
    nib = 4'hF;
    case (idx)
      6'd0:  nib = ER_TYPE[7:4];
      6'd1:  nib = ER_TYPE[3:0];
      6'd2:  nib = ~PROD_ID[7:4];
      6'd3:  nib = ~PROD_ID[3:0];
      6'd4:  nib = 4'hF;
      6'd5:  nib = 4'hF;
      6'd8:  nib = ~MANUF_ID[15:12];
      6'd9:  nib = ~MANUF_ID[11:8];
      6'd10: nib = ~MANUF_ID[7:4];
      6'd11: nib = ~MANUF_ID[3:0];
      6'd12: nib = ~SERIAL[31:28];
      6'd13: nib = ~SERIAL[27:24];
      6'd14: nib = ~SERIAL[23:20];
      6'd15: nib = ~SERIAL[19:16];
      6'd16: nib = ~SERIAL[15:12];
      6'd17: nib = ~SERIAL[11:8];
      6'd18: nib = ~SERIAL[7:4];
      6'd19: nib = ~SERIAL[3:0];
      6'd20: nib = ~DIAG_VEC[15:12];
      6'd21: nib = ~DIAG_VEC[11:8];
      6'd22: nib = ~DIAG_VEC[7:4];
      6'd23: nib = ~DIAG_VEC[3:0];
      6'd32: nib = 4'h0;
      6'd33: nib = 4'h0;
      default: nib = 4'hF;
    endcase
  end

endmodule

// File: rtl/zorro_autoconfig.sv
// Zorro II AutoConfig responder for the IDE card: config reads, base
// latch, shut-up and CFGOUT_n chain.
module zorro_autoconfig
  import autoconfig_pkg::*;
#(
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PROD_ID  = 8'h05,
  parameter logic [31:0] SERIAL   = 32'h00000001,
  parameter logic [7:0]  ER_TYPE  = 8'hD2,
  parameter logic [15:0] DIAG_VEC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] ADDR,
  input  logic [3:0]  DIN,
  input  logic        UDS_n,
  input  logic        AS_n,
  input  logic        RW,
  input  logic        CFGIN_n,
  output logic        CFGOUT_n,
  output logic [3:0]  DOUT,
  output logic        DOE,
  output logic        ide_access,
  output logic        configured,
  output logic        shutup
);

  ac_state_t  state;
  ac_state_t  state_nxt;
  logic [6:0] base;
  logic [3:1] low_nib;
  logic       wr_done;
  logic       cfg_sel;
  logic       commit;
  logic [5:0] idx;
  logic [3:0] rom_nib;
  logic       unused_addr;

  assign unused_addr = ^ADDR[15:7];
  assign idx = ADDR[6:1];

  // RESET term lets DOE fall the instant reset is asserted
  assign cfg_sel = !RESET && !AS_n && !CFGIN_n
                && state == UNCONF
                && ADDR[23:16] == CFG_BASE;

  assign commit = cfg_sel && !RW && !UDS_n && !wr_done;

  autoconfig_rom #(
    .MANUF_ID (MANUF_ID),
    .PROD_ID  (PROD_ID),
    .SERIAL   (SERIAL),
    .ER_TYPE  (ER_TYPE),
    .DIAG_VEC (DIAG_VEC)
  ) u_rom (
    .idx (idx),
    .nib (rom_nib)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= UNCONF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (commit) begin
      if (idx == IDX_BASE_HI)     state_nxt = CONF;
      else if (idx == IDX_SHUTUP) state_nxt = SHUTUP;
    end
  end

  always_comb begin
    DOE        = cfg_sel && RW && !UDS_n;
    DOUT       = DOE ? rom_nib : 4'h0;
    CFGOUT_n   = state == UNCONF;
    configured = state == CONF;
    shutup     = state == SHUTUP;
    ide_access = state == CONF && ADDR[23:17] == base;
  end

  // One commit per bus cycle, rearmed only once AS_n goes high
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      base    <= 7'h00;
      low_nib <= 3'h0;
      wr_done <= 1'b0;
    end else begin
      if (AS_n)        wr_done <= 1'b0;
      else if (commit) wr_done <= 1'b1;
      if (commit && idx == IDX_BASE_LO) low_nib <= DIN[3:1];
      if (commit && idx == IDX_BASE_HI) base <= {DIN, low_nib};
    end
  end

endmodule

// File: tb/tb_zorro_autoconfig.sv
// Scoreboard bench for zorro_autoconfig: stimulus queues expectations,
// a monitor process pops and compares them.
module tb_zorro_autoconfig;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [23:1] ADDR = '0;
  logic [3:0]  DIN = '0;
  logic        UDS_n = 1'b1;
  logic        AS_n = 1'b1;
  logic        RW = 1'b1;
  logic        CFGIN_n = 1'b0;
  logic        CFGOUT_n;
  logic [3:0]  DOUT;
  logic        DOE;
  logic        ide_access;
  logic        configured;
  logic        shutup;

  zorro_autoconfig dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ADDR       (ADDR),
    .DIN        (DIN),
    .UDS_n      (UDS_n),
    .AS_n       (AS_n),
    .RW         (RW),
    .CFGIN_n    (CFGIN_n),
    .CFGOUT_n   (CFGOUT_n),
    .DOUT       (DOUT),
    .DOE        (DOE),
    .ide_access (ide_access),
    .configured (configured),
    .shutup     (shutup)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_DOUT, K_DOE, K_CFGOUT, K_CONF, K_SHUT, K_IDE} kind_t;
  typedef struct {
    kind_t      k;
    logic [3:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  event chk;
  int   n_eval = 0;
  int   n_fail = 0;

  function automatic logic [3:0] actual(kind_t k);
    case (k)
      K_DOUT:   return DOUT;
      K_DOE:    return {3'b0, DOE};
      K_CFGOUT: return {3'b0, CFGOUT_n};
      K_CONF:   return {3'b0, configured};
      K_SHUT:   return {3'b0, shutup};
      K_IDE:    return {3'b0, ide_access};
      default:  return 4'hX;
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [3:0] a;
    forever begin
      @(chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = actual(e.k);
        n_eval++;
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h at %0t",
                   e.name, a, e.v, $time);
        end
      end
    end
  end

  task automatic want(kind_t k, logic [3:0] v, string nm);
    exp_t e;
    e.k = k;
    e.v = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic check();
    #1;
    ->chk;
    #1;
  endtask

  task automatic idle();
    AS_n = 1'b1;
    UDS_n = 1'b1;
    RW = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    idle();
    ADDR = '0;
    DIN = '0;
    want(K_CFGOUT, 4'h1, "rst_cfgout");
    want(K_CONF, 4'h0, "rst_configured");
    want(K_SHUT, 4'h0, "rst_shutup");
    want(K_DOE, 4'h0, "rst_doe");
    want(K_DOUT, 4'h0, "rst_dout");
    want(K_IDE, 4'h0, "rst_ide");
    check();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic rd(logic [23:0] a, logic [3:0] v, logic doe, string nm);
    @(negedge CLK);
    ADDR = a[23:1];
    RW = 1'b1;
    AS_n = 1'b0;
    UDS_n = 1'b0;
    want(K_DOE, {3'b0, doe}, {nm, "_doe"});
    if (doe) want(K_DOUT, v, {nm, "_dout"});
    check();
    @(negedge CLK);
    idle();
  endtask

  task automatic wr(logic [23:0] a, logic [3:0] d);
    @(negedge CLK);
    ADDR = a[23:1];
    DIN = d;
    RW = 1'b0;
    AS_n = 1'b0;
    UDS_n = 1'b0;
    want(K_DOE, 4'h0, "wr_doe");
    check();
    @(negedge CLK);
    idle();
  endtask

  // Write held for six clocks; DIN changes after the first commit edge
  task automatic wr_stretched(logic [23:0] a, logic [3:0] d0,
                              logic [3:0] d1);
    @(negedge CLK);
    ADDR = a[23:1];
    DIN = d0;
    RW = 1'b0;
    AS_n = 1'b0;
    UDS_n = 1'b0;
    @(negedge CLK);
    DIN = d1;
    repeat (5) @(negedge CLK);
    idle();
  endtask

  task automatic ide_at(logic [23:0] a, logic v, string nm);
    @(negedge CLK);
    ADDR = a[23:1];
    want(K_IDE, {3'b0, v}, nm);
    check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout");
    $fatal(1);
  end

  initial begin
    do_reset();

    rd(24'hE80000, 4'hD, 1'b1, "idx0");
    rd(24'hE80002, 4'h2, 1'b1, "idx1");
    rd(24'hE80004, 4'hF, 1'b1, "idx2");
    rd(24'hE80006, 4'hA, 1'b1, "idx3");
    rd(24'hE80012, 4'h8, 1'b1, "idx9");
    rd(24'hE80016, 4'h4, 1'b1, "idx11");
    rd(24'hE80026, 4'hE, 1'b1, "idx19");
    rd(24'hE80040, 4'h0, 1'b1, "idx32");
    rd(24'hE80050, 4'hF, 1'b1, "idx40");
    rd(24'hE90000, 4'h0, 1'b0, "not_e8");

    @(negedge CLK);
    ADDR = 24'hE80000 >> 1;
    RW = 1'b1;
    AS_n = 1'b0;
    UDS_n = 1'b1;
    want(K_DOE, 4'h0, "uds_high_doe");
    check();
    UDS_n = 1'b0;
    want(K_DOE, 4'h1, "uds_low_doe");
    want(K_DOUT, 4'hD, "uds_low_dout");
    check();
    AS_n = 1'b1;
    want(K_DOE, 4'h0, "as_high_doe");
    check();
    idle();

    wr(24'hE8004A, 4'h4);
    @(negedge CLK);
    ADDR = 24'hE80048 >> 1;
    DIN = 4'hE;
    RW = 1'b0;
    AS_n = 1'b0;
    UDS_n = 1'b0;
    want(K_CFGOUT, 4'h1, "pre_cfgout");
    want(K_CONF, 4'h0, "pre_configured");
    check();
    @(negedge CLK);
    idle();
    want(K_CONF, 4'h1, "post_configured");
    want(K_CFGOUT, 4'h0, "post_cfgout");
    want(K_SHUT, 4'h0, "post_shutup");
    check();
    ide_at(24'hE40000, 1'b1, "ide_e4");
    ide_at(24'hE5FFFE, 1'b1, "ide_e5_top");
    ide_at(24'hE60000, 1'b0, "ide_e6");
    ide_at(24'hE3FFFE, 1'b0, "ide_e3");
    rd(24'hE80000, 4'h0, 1'b0, "conf_rd");

    @(negedge CLK);
    ADDR = 24'hE40000 >> 1;
    RW = 1'b1;
    AS_n = 1'b0;
    UDS_n = 1'b0;
    want(K_IDE, 4'h1, "mid_ide");
    check();
    RESET = 1'b1;
    want(K_IDE, 4'h0, "arst_ide");
    want(K_CONF, 4'h0, "arst_configured");
    want(K_CFGOUT, 4'h1, "arst_cfgout");
    want(K_DOE, 4'h0, "arst_doe");
    check();
    @(negedge CLK);
    ADDR = 24'hE80000 >> 1;
    want(K_DOE, 4'h0, "inrst_doe");
    check();
    @(negedge CLK);
    RESET = 1'b0;
    want(K_DOE, 4'h1, "postrst_doe");
    want(K_DOUT, 4'hD, "postrst_dout");
    check();
    idle();

    do_reset();
    wr(24'hE8004C, 4'h0);
    want(K_SHUT, 4'h1, "su_shutup");
    want(K_CFGOUT, 4'h0, "su_cfgout");
    want(K_CONF, 4'h0, "su_configured");
    check();
    wr(24'hE80048, 4'hE);
    want(K_CONF, 4'h0, "su_late48");
    want(K_SHUT, 4'h1, "su_held");
    check();
    rd(24'hE80000, 4'h0, 1'b0, "su_rd");
    ide_at(24'hE00000, 1'b0, "su_ide");

    do_reset();
    CFGIN_n = 1'b1;
    rd(24'hE80000, 4'h0, 1'b0, "cfgin_rd");
    wr(24'hE8004A, 4'h4);
    wr(24'hE80048, 4'hE);
    want(K_CONF, 4'h0, "cfgin_configured");
    want(K_CFGOUT, 4'h1, "cfgin_cfgout");
    check();
    CFGIN_n = 1'b0;
    wr(24'hE80048, 4'hE);
    want(K_CONF, 4'h1, "nolo_configured");
    check();
    ide_at(24'hE00000, 1'b1, "nolo_ide_e0");
    ide_at(24'hE40000, 1'b0, "nolo_ide_e4");

    do_reset();
    wr_stretched(24'hE8004A, 4'h4, 4'h6);
    wr(24'hE80048, 4'hE);
    ide_at(24'hE40000, 1'b1, "str_ide_e4");
    ide_at(24'hE60000, 1'b0, "str_ide_e6");

    do_reset();
    wr_stretched(24'hE8004A, 4'h4, 4'h6);
    wr(24'hE8004A, 4'h6);
    wr(24'hE80048, 4'hE);
    ide_at(24'hE60000, 1'b1, "again_ide_e6");
    ide_at(24'hE40000, 1'b0, "again_ide_e4");

    #5;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
